// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR voter error monitor: voter limits and FSM state type.
package tmr_pkg;

  // Upper bound on voter err lines a single monitor can watch.
  localparam int unsigned TMR_MAX_VOTERS = 32;

  // Classification FSM; encodings are visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TRANSIENT  = 2'd1,
    ST_PERSISTENT = 2'd2,
    ST_RESYNC     = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count up by one per inc, hold at all-ones; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tmr_err_monitor.sv
// Watches voter disagreement lines, counts error cycles, keeps sticky per-voter
// flags and escalates long error runs into a resync request.
module tmr_err_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned N_VOTERS       = 4,
  parameter int unsigned PERSIST_CYCLES = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_VOTERS-1:0] err_i,
  input  logic                clear_i,
  input  logic                resync_ack_i,
  output logic                resync_req_o,
  output logic                persistent_o,
  output logic [CNT_W-1:0]    err_count_o,
  output logic [N_VOTERS-1:0] fault_vec_o,
  output logic [1:0]          state_o
);

  localparam int unsigned      RUN_W    = $clog2(PERSIST_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PERSIST_CYCLES);

  tmr_state_e          state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [N_VOTERS-1:0] fault_q, fault_d;
  logic                req_q, pers_q;
  logic                err_cycle;

  assign err_cycle = |err_i;

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_i),
    .inc   (err_cycle),
    .count (err_count_o)
  );

  // Next-state logic: run length tracked only while watching for a persistent fault.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        if (err_cycle) begin
          state_d = ST_TRANSIENT;
          run_d   = RUN_ONE;
        end
      end
      ST_TRANSIENT: begin
        if (err_cycle) begin
          run_d = run_q + RUN_ONE;
          if (run_d == RUN_LAST) state_d = ST_PERSISTENT;
        end else begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end
      ST_PERSISTENT: state_d = ST_RESYNC;
      ST_RESYNC: begin
        if (resync_ack_i) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
    fault_d = clear_i ? '0 : (fault_q | err_i);
  end

  // State, sticky flags and registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      fault_q <= '0;
      req_q   <= 1'b0;
      pers_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fault_q <= fault_d;
      req_q   <= (state_d == ST_RESYNC);
      pers_q  <= (state_d == ST_PERSISTENT);
    end
  end

  assign resync_req_o = req_q;
  assign persistent_o = pers_q;
  assign fault_vec_o  = fault_q;
  assign state_o      = state_q;

endmodule

// File: doc/tmr_err_monitor.md
TMR_ERR_MONITOR -- requirements
Module: tmr_err_monitor

Interface
REQ-001 Parameter N_VOTERS, default 4, number of voter err lines monitored (1..32).
REQ-002 Parameter PERSIST_CYCLES, default 8, consecutive error cycles that classify a fault as persistent (2..255).
REQ-003 Parameter CNT_W, default 16, width of the error event counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 err_i  input  N_VOTERS  err outputs of downstream-connected voters, bit i = voter i disagreement.
REQ-007 clear_i  input  1  clears err_count_o and fault_vec_o.
REQ-008 resync_ack_i  input  1  acknowledge from resync controller.
REQ-009 resync_req_o  output  1  request to re-synchronise triplicated state.
REQ-010 persistent_o  output  1  one-cycle pulse on persistent-fault classification.
REQ-011 err_count_o  output  CNT_W  saturating count of error cycles.
REQ-012 fault_vec_o  output  N_VOTERS  sticky per-voter error flags.
REQ-013 state_o  output  2  current FSM state encoding.

Function
REQ-014 An error cycle SHALL be any cycle with |err_i == 1.
REQ-015 err_count_o SHALL increment by exactly 1 per error cycle, regardless of how many bits are set, and saturate at 2^CNT_W-1.
REQ-016 fault_vec_o[i] SHALL set the cycle after err_i[i]=1 and hold until clear_i or rst.
REQ-017 clear_i SHALL zero err_count_o and fault_vec_o next cycle; clear wins over a same-cycle increment/set.
REQ-018 clear_i SHALL NOT affect FSM state, run counter or resync_req_o.
REQ-019 FSM states: IDLE=0, TRANSIENT=1, PERSISTENT=2, RESYNC=3; state_o reflects registered state.
REQ-020 IDLE: error cycle -> TRANSIENT with run counter = 1; else stay.
REQ-021 TRANSIENT: error cycle -> run+1; when run+1 == PERSIST_CYCLES -> PERSISTENT; non-error cycle -> IDLE, run = 0.
REQ-022 PERSISTENT: lasts exactly one cycle, persistent_o = 1 only in this state, then -> RESYNC unconditionally.
REQ-023 RESYNC: resync_req_o = 1 (registered, asserted from first RESYNC cycle) until resync_ack_i sampled high; then -> IDLE, run = 0, resync_req_o = 0 next cycle.
REQ-024 resync_ack_i outside RESYNC SHALL be ignored.
REQ-025 In PERSISTENT and RESYNC, error cycles SHALL still update err_count_o/fault_vec_o but not the run counter.
REQ-026 Run counter SHALL be ceil(log2(PERSIST_CYCLES+1)) bits and never wrap.
REQ-027 Latency: err_i to err_count_o/fault_vec_o update = 1 cycle; PERSIST_CYCLES-th consecutive error cycle to persistent_o = 1 cycle; to resync_req_o = 2 cycles.

Reset
REQ-028 rst SHALL set state IDLE, run 0, err_count_o 0, fault_vec_o 0, resync_req_o 0, persistent_o 0; rst overrides all inputs.
REQ-029 rst asserted mid-RESYNC SHALL drop resync_req_o the following cycle without waiting for ack.

Structure
REQ-030 FSM state enum (2-bit) SHALL live in shared package tmr_pkg alongside the voter definitions.
REQ-031 err_count_o SHALL be implemented by one sub-module sat_counter (params WIDTH; ports clk, rst, clr, inc, count).
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-033 rst, err_i=4'b0000 for 10 cycles -> all outputs 0, state_o=0.
REQ-034 err_i=4'b0101 for 3 cycles then 0 (PERSIST_CYCLES=8) -> err_count_o=3, fault_vec_o=4'b0101, state returns IDLE, resync_req_o never 1.
REQ-035 err_i=4'b0010 for 8 cycles -> persistent_o pulses 1 cycle after 8th, resync_req_o high next cycle and holds; ack after 5 cycles -> req low one cycle later, state_o=0.
REQ-036 CNT_W=4, err_i nonzero 20 cycles -> err_count_o sticks at 15.
REQ-037 clear_i=1 in same cycle as err_i=4'b1000 -> err_count_o=0, fault_vec_o=0 next cycle; FSM still enters TRANSIENT.
REQ-038 rst pulsed while in RESYNC with no ack -> resync_req_o=0, state_o=0 next cycle.
